// File: rtl/debug_capture_framer.sv
// Debug snapshot framer: picks one debug channel and writes framed bursts
// (header, FRAME_LEN samples, trailer) into a downstream FIFO write port.
// Frames start free-running, on an armed single shot, or on a value change.
module debug_capture_framer #(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 4096,
  parameter int USEDW_W    = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] debug_in,
  input  logic [7:0]               chan_sel,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic [USEDW_W-1:0]       fifo_wrusedw,
  output logic                     fifo_wrreq,
  output logic [DATA_W-1:0]        fifo_data,
  output logic                     busy,
  output logic [15:0]              frame_seq,
  output logic [15:0]              drop_count
);

  // Highest fill level that still leaves space for one complete frame.
  localparam int ROOM_MAX = FIFO_DEPTH - (FRAME_LEN + 2);
  localparam int CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_CHANGE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_TRAILER,
    S_GAP
  } state_t;

  state_t             state, state_n;
  logic [7:0]         live_ch;
  logic [7:0]         ch_q, ch_n;
  logic [DATA_W-1:0]  live_word;
  logic [DATA_W-1:0]  frame_word;
  logic [DATA_W-1:0]  header_word;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [1:0]         gap_q, gap_n;
  logic [7:0]         chan_sel_q;
  logic               prev_valid;
  logic [DATA_W-1:0]  prev_word;
  logic               arm_pending;
  logic               room;
  logic               change_hit;
  logic               trigger;
  logic               start;
  logic               wrreq_n;
  logic [DATA_W-1:0]  data_n;
  logic               seq_inc;

  // Out-of-range channel selects fall back to channel 0.
  assign live_ch     = ({1'b0, chan_sel} < 9'(NUM_CH)) ? chan_sel : 8'd0;
  assign live_word   = debug_in[live_ch*DATA_W +: DATA_W];
  assign frame_word  = debug_in[ch_q*DATA_W +: DATA_W];
  assign header_word = DATA_W'({8'hA5, live_ch, frame_seq});
  assign room        = (32'(fifo_wrusedw) <= 32'(ROOM_MAX));

  // A channel switch invalidates the stored value for the cycle it happens,
  // so the first sample of the new channel never counts as a change.
  assign change_hit = prev_valid && (chan_sel == chan_sel_q) &&
                      (mode == MODE_CHANGE) && (live_word != prev_word);

  // Start condition for the current mode; only acted upon in IDLE with room.
  always_comb begin
    trigger = 1'b0;
    case (mode)
      MODE_FREE:   trigger = 1'b1;
      MODE_SINGLE: trigger = arm_pending;
      MODE_CHANGE: trigger = change_hit;
      default:     trigger = 1'b0;
    endcase
    start = (state == S_IDLE) && room && trigger;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and the next value of each registered output.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n = state;
    wrreq_n = 1'b0;
    data_n  = fifo_data;
    ch_n    = ch_q;
    cnt_n   = cnt_q;
    gap_n   = gap_q;
    seq_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_HEADER;
          wrreq_n = 1'b1;
          data_n  = header_word;
          ch_n    = live_ch;
        end
      end
      S_HEADER: begin
        state_n = S_PAYLOAD;
        wrreq_n = 1'b1;
        data_n  = frame_word;
        cnt_n   = '0;
      end
      S_PAYLOAD: begin
        wrreq_n = 1'b1;
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          state_n = S_TRAILER;
          data_n  = '1;
        end else begin
          data_n = frame_word;
          cnt_n  = cnt_q + 1'b1;
        end
      end
      S_TRAILER: begin
        state_n = S_GAP;
        gap_n   = 2'd0;
        seq_inc = 1'b1;
      end
      S_GAP: begin
        if (gap_q == 2'd2) state_n = S_IDLE;
        else               gap_n   = gap_q + 2'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output registers, frame bookkeeping, arm and change tracking.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (reset) begin
      fifo_wrreq  <= 1'b0;
      fifo_data   <= '0;
      busy        <= 1'b0;
      frame_seq   <= 16'd0;
      drop_count  <= 16'd0;
      ch_q        <= 8'd0;
      cnt_q       <= '0;
      gap_q       <= 2'd0;
      arm_pending <= 1'b0;
      prev_valid  <= 1'b0;
      prev_word   <= '0;
      chan_sel_q  <= 8'd0;
    end else begin
      fifo_wrreq <= wrreq_n;
      fifo_data  <= data_n;
      busy       <= (state_n != S_IDLE);
      ch_q       <= ch_n;
      cnt_q      <= cnt_n;
      gap_q      <= gap_n;
      if (seq_inc) frame_seq <= frame_seq + 16'd1;
      if (change_hit && !start && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
      // A single-shot start consumes the request; arms seen in that same
      // cycle fold into the frame being started.
      if (start && (mode == MODE_SINGLE))
        arm_pending <= 1'b0;
      else if (arm && (mode == MODE_SINGLE))
        arm_pending <= 1'b1;
      prev_word  <= live_word;
      prev_valid <= 1'b1;
      chan_sel_q <= chan_sel;
    end
  end

endmodule
